// File: rtl/fft_twiddle_addr_gen_if.sv
// Port bundle for fft_twiddle_addr_gen: stage-controller handshake, twiddle ROM port, output stream.
// FFT_TWG_INVERSE_EN adds the inverse select carried with start.
interface fft_twiddle_addr_gen_if #(
    parameter int unsigned LOG2N = 8,
    parameter int unsigned TW_W  = 32
);
    localparam int unsigned STG_W = $clog2(LOG2N);
    localparam int unsigned BF_W  = LOG2N - 1;

    logic             start;
    logic             busy;
    logic             done;
    logic [STG_W-1:0] rom_stage_idx;
    logic [LOG2N-1:0] rom_addr;
    logic [TW_W-1:0]  rom_twiddle;
    logic             tw_valid;
    logic             tw_ready;
    logic [TW_W-1:0]  tw_data;
    logic [STG_W-1:0] tw_stage;
    logic [BF_W-1:0]  tw_bfly;
`ifdef FFT_TWG_INVERSE_EN
    logic             inverse;
`endif

    // Sequencer side.
    modport slave (
        input  start,
        input  rom_twiddle,
        input  tw_ready,
`ifdef FFT_TWG_INVERSE_EN
        input  inverse,
`endif
        output busy,
        output done,
        output rom_stage_idx,
        output rom_addr,
        output tw_valid,
        output tw_data,
        output tw_stage,
        output tw_bfly
    );

    // Controller / ROM / datapath side.
    modport master (
        output start,
        output rom_twiddle,
        output tw_ready,
`ifdef FFT_TWG_INVERSE_EN
        output inverse,
`endif
        input  busy,
        input  done,
        input  rom_stage_idx,
        input  rom_addr,
        input  tw_valid,
        input  tw_data,
        input  tw_stage,
        input  tw_bfly
    );
endinterface

// File: rtl/fft_twiddle_addr_gen.sv
// Twiddle request sequencer for a radix-2 DIT FFT: walks stages x butterflies, reads the ROM,
// and streams tagged twiddles through a 2-entry buffer. FFT_TWG_INVERSE_EN enables conjugation.
module fft_twiddle_addr_gen #(
    parameter int unsigned N     = 256,
    parameter int unsigned LOG2N = 8,
    parameter int unsigned TW_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_twiddle_addr_gen_if.slave tw_if
);
    localparam int unsigned STG_W = $clog2(LOG2N);
    localparam int unsigned BF_W  = LOG2N - 1;
    localparam int unsigned HALF  = TW_W / 2;
    localparam logic [STG_W-1:0] LAST_STG = STG_W'(LOG2N - 1);
    localparam logic [BF_W-1:0]  LAST_BF  = BF_W'(N / 2 - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_clr;

    logic [STG_W-1:0] r_stg;
    logic [BF_W-1:0]  r_bf;
    logic [STG_W-1:0] r_stg_d;
    logic [BF_W-1:0]  r_bf_d;
    logic             r_inflight;

    logic [TW_W-1:0]  r_buf_data [2];
    logic [STG_W-1:0] r_buf_stg  [2];
    logic [BF_W-1:0]  r_buf_bf   [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_occ;

    logic [LOG2N-1:0] w_mask;
    logic [LOG2N-1:0] w_addr;
    logic [2:0]       w_level;
    logic             w_pop;
    logic             w_issue;
    logic             w_last;
    logic [1:0]       w_occ_nxt;
    logic [TW_W-1:0]  w_cap_data;

    // Twiddle index: low stg bits of bf, scaled up to the N-point table.
    always_comb begin
        w_mask = (LOG2N'(1) << r_stg) - LOG2N'(1);
        w_addr = ({1'b0, r_bf} & w_mask) << (LAST_STG - r_stg);
    end

    // occ + inflight never exceeds 2, so issuing only below 2 after the pop keeps the buffer safe.
    always_comb begin
        w_pop     = (r_occ != 2'd0) & tw_if.tw_ready;
        w_level   = {1'b0, r_occ} + {2'b00, r_inflight};
        w_issue   = (r_state == StRun) && ((w_level - {2'b00, w_pop}) < 3'd2);
        w_last    = w_issue && (r_stg == LAST_STG) && (r_bf == LAST_BF);
        w_occ_nxt = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (tw_if.start) begin
                    w_state_nxt = StRun;
                    w_clr       = 1'b1;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_nxt = StDrain;
                end
            end
            // Look at next-cycle occupancy so done follows the final handshake directly.
            StDrain: begin
                if (!r_inflight && (w_occ_nxt == 2'd0)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg      <= '0;
            r_bf       <= '0;
            r_stg_d    <= '0;
            r_bf_d     <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_clr) begin
                r_stg <= '0;
                r_bf  <= '0;
            end else if (w_issue) begin
                if (r_bf == LAST_BF) begin
                    r_bf  <= '0;
                    r_stg <= r_stg + STG_W'(1);
                end else begin
                    r_bf <= r_bf + BF_W'(1);
                end
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_stg_d <= r_stg;
                r_bf_d  <= r_bf;
            end
        end
    end

`ifdef FFT_TWG_INVERSE_EN
    logic            r_inverse;
    logic [HALF-1:0] w_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inverse <= 1'b0;
        end else if ((r_state == StIdle) && tw_if.start) begin
            r_inverse <= tw_if.inverse;
        end
    end

    // Conjugate: negate im, saturating the most negative value.
    always_comb begin
        w_im = tw_if.rom_twiddle[HALF-1:0];
        if (r_inverse) begin
            if (w_im == {1'b1, {(HALF-1){1'b0}}}) begin
                w_im = {1'b0, {(HALF-1){1'b1}}};
            end else begin
                w_im = HALF'(0) - w_im;
            end
        end
        w_cap_data = {tw_if.rom_twiddle[TW_W-1:HALF], w_im};
    end
`else
    assign w_cap_data = tw_if.rom_twiddle;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_stg[i]  <= '0;
                r_buf_bf[i]   <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf_data[r_wr_ptr] <= w_cap_data;
                r_buf_stg[r_wr_ptr]  <= r_stg_d;
                r_buf_bf[r_wr_ptr]   <= r_bf_d;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= w_occ_nxt;
        end
    end

    assign tw_if.busy          = (r_state == StRun) || (r_state == StDrain);
    assign tw_if.done          = (r_state == StDone);
    assign tw_if.rom_stage_idx = r_stg;
    assign tw_if.rom_addr      = w_addr;
    assign tw_if.tw_valid      = (r_occ != 2'd0);
    assign tw_if.tw_data       = r_buf_data[r_rd_ptr];
    assign tw_if.tw_stage      = r_buf_stg[r_rd_ptr];
    assign tw_if.tw_bfly       = r_buf_bf[r_rd_ptr];
endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Scoreboard bench for fft_twiddle_addr_gen: model ROM, expected-word queue, stall/reset/restart runs.
// Builds with or without FFT_TWG_INVERSE_EN.
module tb_fft_twiddle_addr_gen;
    localparam int unsigned N     = 256;
    localparam int unsigned LOG2N = 8;
    localparam int unsigned TW_W  = 32;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  stg;
        logic [6:0]  bf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_twiddle_addr_gen_if #(.LOG2N(LOG2N), .TW_W(TW_W)) u_if ();

    fft_twiddle_addr_gen #(
        .N    (N),
        .LOG2N(LOG2N),
        .TW_W (TW_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .tw_if(u_if.slave)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   pat_mode  = 1'b1;
    bit   rnd_ready = 1'b0;
    int   cyc = 0;
    int   run_t0 = 0;
    int   done_cnt = 0;
    int   done_rel = 0;
    int   last_pop_rel = 0;
    int   first_valid_rel = 0;
    int   pop_cnt = 0;
    int   pop_base = 0;
    int   occ_bad = 0;
    bit   prev_stall = 1'b0;
    logic [41:0] held;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [2:0] s, input logic [7:0] a);
        if (pat_mode) return {4'hA, 9'd0, s, 8'h00, a};
        return s[0] ? 32'h2000_0010 : 32'h1000_8000;
    endfunction

    // Non-pattern mode is only used with inverse=1: conjugated constants.
    function automatic logic [31:0] exp_word(input logic [2:0] s, input logic [7:0] a);
        if (pat_mode) return rom_word(s, a);
        return s[0] ? 32'h2000_FFF0 : 32'h1000_7FFF;
    endfunction

    task automatic push_expected();
        exp_t e;
        int   a;
        for (int s = 0; s < int'(LOG2N); s++) begin
            for (int b = 0; b < int'(N / 2); b++) begin
                a      = (b % (1 << s)) * ((N / 2) >> s);
                e.data = exp_word(3'(s), 8'(a));
                e.stg  = 3'(s);
                e.bf   = 7'(b);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(posedge clk) u_if.rom_twiddle <= rom_word(u_if.rom_stage_idx, u_if.rom_addr);
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        u_if.tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            u_if.tw_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.tw_valid && (first_valid_rel == 0)) first_valid_rel = cyc - run_t0 + 1;
            if (prev_stall) begin
                check_val("stall_hold", {u_if.tw_data, u_if.tw_stage, u_if.tw_bfly}, held);
            end
            prev_stall = u_if.tw_valid && !u_if.tw_ready;
            held       = {u_if.tw_data, u_if.tw_stage, u_if.tw_bfly};
            if (u_if.tw_valid && u_if.tw_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("tw_data", u_if.tw_data, mon_e.data);
                    check_val("tw_stage", u_if.tw_stage, mon_e.stg);
                    check_val("tw_bfly", u_if.tw_bfly, mon_e.bf);
                    if (pat_mode && mon_e.stg == 3'd3 && mon_e.bf == 7'd13)
                        check_val("addr_s3_b13", u_if.tw_data[7:0], 80);
                    if (pat_mode && mon_e.stg == 3'd7 && mon_e.bf == 7'd127)
                        check_val("addr_s7_b127", u_if.tw_data[7:0], 127);
                end
                pop_cnt++;
                last_pop_rel = cyc - run_t0 + 1;
            end
            if (u_if.done) begin
                done_cnt++;
                done_rel = cyc - run_t0 + 1;
            end
            if (dut.r_occ > 2'd2) occ_bad++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start      = 1'b0;
        run_t0          = cyc;
        first_valid_rel = 0;
        pop_base        = pop_cnt;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) check_val("done_timeout", done_cnt, target);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_busy"}, u_if.busy, 0);
        check_val({tag, "_done"}, u_if.done, 0);
        check_val({tag, "_valid"}, u_if.tw_valid, 0);
        check_val({tag, "_data"}, u_if.tw_data, 0);
        check_val({tag, "_stage"}, u_if.tw_stage, 0);
        check_val({tag, "_bfly"}, u_if.tw_bfly, 0);
        check_val({tag, "_rom_stg"}, u_if.rom_stage_idx, 0);
        check_val({tag, "_rom_addr"}, u_if.rom_addr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        u_if.start = 1'b0;
`ifdef FFT_TWG_INVERSE_EN
        u_if.inverse = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("idle");

        // Unstalled run with cycle-accurate timing.
        push_expected();
        start_pulse();
        @(negedge clk);
        check_val("c1_rom_addr", u_if.rom_addr, 0);
        check_val("c1_rom_stg", u_if.rom_stage_idx, 0);
        check_val("c1_busy", u_if.busy, 1);
        check_val("c1_valid", u_if.tw_valid, 0);
        @(negedge clk);
        check_val("c2_valid", u_if.tw_valid, 0);
        wait_done(1);
        check_val("first_valid_cycle", first_valid_rel, 3);
        check_val("last_word_cycle", last_pop_rel, 1026);
        check_val("done_cycle", done_rel, 1027);
        check_val("busy_at_done", u_if.busy, 0);
        check_val("run1_left", exp_q.size(), 0);
        check_val("run1_words", pop_cnt - pop_base, 1024);

        // Start in the IDLE cycle right after done; random backpressure; start mid-run.
        push_expected();
        rnd_ready = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start      = 1'b0;
        run_t0          = cyc;
        first_valid_rel = 0;
        pop_base        = pop_cnt;
        @(negedge clk);
        check_val("restart_busy", u_if.busy, 1);
        repeat (300) @(negedge clk);
        check_val("mid_run_busy", u_if.busy, 1);
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        wait_done(2);
        u_if.start = 1'b1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("start_in_done_ignored", u_if.busy, 0);
        check_val("run2_left", exp_q.size(), 0);
        check_val("run2_words", pop_cnt - pop_base, 1024);
        check_val("done_pulses", done_cnt, 2);
        check_val("occ_bound", occ_bad, 0);
        rnd_ready = 1'b0;

        // Asynchronous reset after 500 words, then a fresh run.
        push_expected();
        start_pulse();
        n = 0;
        while ((pop_cnt - pop_base) < 500 && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("reached_500", (pop_cnt - pop_base) >= 500, 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_expected();
        start_pulse();
        @(negedge clk);
        check_val("rst_restart_rom_stg", u_if.rom_stage_idx, 0);
        check_val("rst_restart_busy", u_if.busy, 1);
        wait_done(3);
        check_val("run3_done_cycle", done_rel, 1027);
        check_val("run3_left", exp_q.size(), 0);
        check_val("run3_words", pop_cnt - pop_base, 1024);

`ifdef FFT_TWG_INVERSE_EN
        pat_mode     = 1'b0;
        u_if.inverse = 1'b1;
        push_expected();
        start_pulse();
        u_if.inverse = 1'b0;
        wait_done(4);
        check_val("inv_left", exp_q.size(), 0);
        check_val("inv_words", pop_cnt - pop_base, 1024);
        pat_mode = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
